conv2_result_collector: RTL and testbench



---
 rtl/conv2_pkg.sv | 22 ++
 rtl/conv2_relu_sat.sv | 33 +++
 rtl/conv2_result_collector.sv | 116 +++++++++++
 tb/tb_conv2_result_collector.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/conv2_pkg.sv
// Shared types and constants for the conv-layer-2 result collector.
package conv2_pkg;
  localparam int IN_W_DEF  = 17;
  localparam int OUT_W_DEF = 16;

  localparam int OUT_MAX = (1 << (OUT_W_DEF - 1)) - 1;
  localparam int OUT_MIN = -(1 << (OUT_W_DEF - 1));

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    FULL = 2'd2
  } state_t;

  function automatic int sat_max(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

  function automatic int sat_min(input int w);
    return -(1 << (w - 1));
  endfunction
endpackage

// File: rtl/conv2_relu_sat.sv
// Combinational ReLU followed by signed saturation to the stored width.
module conv2_relu_sat
  import conv2_pkg::*;
#(
  parameter int IN_W    = IN_W_DEF,
  parameter int OUT_W   = OUT_W_DEF,
  parameter int RELU_EN = 1,
  parameter int SAT_HI  = OUT_MAX,
  parameter int SAT_LO  = OUT_MIN
) (
  input  logic signed [IN_W-1:0]  din,
  output logic signed [OUT_W-1:0] dout,
  output logic                    clip
);
  localparam logic signed [IN_W-1:0] HI = IN_W'(SAT_HI);
  localparam logic signed [IN_W-1:0] LO = IN_W'(SAT_LO);

  logic signed [IN_W-1:0] v;

  always_comb begin
    v = din;
    if (RELU_EN != 0 && din[IN_W-1]) v = '0;
    clip = 1'b0;
    dout = v[OUT_W-1:0];
    if (v > HI) begin
      dout = HI[OUT_W-1:0];
      clip = 1'b1;
    end else if (v < LO) begin
      dout = LO[OUT_W-1:0];
      clip = 1'b1;
    end
  end
endmodule

// File: rtl/conv2_result_collector.sv
// Collects conv-layer-2 adder sums into a raster-ordered feature-map buffer
// with a registered read port for the pooling stage.
module conv2_result_collector
  import conv2_pkg::*;
#(
  parameter int IN_W    = IN_W_DEF,
  parameter int OUT_W   = OUT_W_DEF,
  parameter int ROWS    = 8,
  parameter int COLS    = 8,
  parameter int RELU_EN = 1,
  parameter int AW      = $clog2(ROWS * COLS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic                   clear,
  input  logic                   in_valid,
  input  logic signed [IN_W-1:0] in_data,
  input  logic                   rd_en,
  input  logic [AW-1:0]          rd_addr,
  output logic [OUT_W-1:0]       rd_data,
  output logic                   rd_valid,
  output logic                   frame_done,
  output logic                   busy,
  output logic                   overflow,
  output logic                   sat_flag
);
  localparam int DEPTH = ROWS * COLS;
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  state_t state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic ov_d, sat_d, fd_d, accept, clip, in_range;
  logic signed [OUT_W-1:0] sat_val;
  logic [OUT_W-1:0] mem [DEPTH];

  conv2_relu_sat #(
    .IN_W    (IN_W),
    .OUT_W   (OUT_W),
    .RELU_EN (RELU_EN),
    .SAT_HI  (sat_max(OUT_W)),
    .SAT_LO  (sat_min(OUT_W))
  ) u_relu_sat (
    .din  (in_data),
    .dout (sat_val),
    .clip (clip)
  );

  // A power-of-two buffer has no unreachable addresses.
  if (DEPTH == (1 << AW)) begin : g_full_range
    assign in_range = 1'b1;
  end else begin : g_part_range
    assign in_range = (rd_addr < AW'(DEPTH));
  end

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    ov_d     = overflow;
    sat_d    = sat_flag;
    fd_d     = 1'b0;
    accept   = 1'b0;
    if (enable) begin
      if (clear) begin
        state_d  = IDLE;
        wr_ptr_d = '0;
        ov_d     = 1'b0;
        sat_d    = 1'b0;
      end else if (in_valid) begin
        case (state_q)
          IDLE, FILL: begin
            accept = 1'b1;
            sat_d  = sat_flag | clip;
            if (wr_ptr_q == LAST) begin
              state_d  = FULL;
              wr_ptr_d = '0;
              fd_d     = 1'b1;
            end else begin
              state_d  = FILL;
              wr_ptr_d = wr_ptr_q + 1'b1;
            end
          end
          FULL:    ov_d = 1'b1;
          default: state_d = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      overflow   <= 1'b0;
      sat_flag   <= 1'b0;
      frame_done <= 1'b0;
      rd_valid   <= 1'b0;
      rd_data    <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      overflow   <= ov_d;
      sat_flag   <= sat_d;
      frame_done <= fd_d;
      rd_valid   <= rd_en;
      if (rd_en) rd_data <= in_range ? mem[rd_addr] : '0;
    end
  end

  // Buffer is deliberately not reset; read-before-write returns old data.
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr_q] <= sat_val;
  end

  assign busy = (state_q == FILL);
endmodule

// File: tb/tb_conv2_result_collector.sv
// Bench for conv2_result_collector: an 8x8 ReLU instance and an 8x7 no-ReLU
// instance share stimulus and are checked against a per-instance reference model.
module tb_conv2_result_collector;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic enable, clear, in_valid, rd_en;
  logic signed [16:0] in_data;
  logic [5:0] rd_addr;

  logic [15:0] rdd [2];
  logic rdv [2], fdn [2], bsy [2], ovf [2], sat [2];

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  conv2_result_collector #(.ROWS(8), .COLS(8), .RELU_EN(1)) dut_relu (
    .clk(clk), .rst_n(rst_n), .enable(enable), .clear(clear),
    .in_valid(in_valid), .in_data(in_data), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rdd[0]), .rd_valid(rdv[0]), .frame_done(fdn[0]), .busy(bsy[0]),
    .overflow(ovf[0]), .sat_flag(sat[0])
  );

  conv2_result_collector #(.ROWS(8), .COLS(7), .RELU_EN(0)) dut_lin (
    .clk(clk), .rst_n(rst_n), .enable(enable), .clear(clear),
    .in_valid(in_valid), .in_data(in_data), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rdd[1]), .rd_valid(rdv[1]), .frame_done(fdn[1]), .busy(bsy[1]),
    .overflow(ovf[1]), .sat_flag(sat[1])
  );

  // Reference model: instance k has depth[k] slots and ReLU relu[k].
  localparam int S_IDLE = 0, S_FILL = 1, S_FULL = 2;
  int depth [2] = '{64, 56};
  int relu  [2] = '{1, 0};
  int m_state [2];
  int m_ptr [2];
  bit m_ov [2], m_sat [2], m_fd [2], m_rv [2];
  logic [15:0] m_rd [2];
  logic [15:0] m_mem [2][64];

  function automatic int sat_of(input int x, input int use_relu, output bit clipped);
    int v;
    v = x;
    clipped = 1'b0;
    if (use_relu != 0 && v < 0) v = 0;
    if (v > 32767) begin v = 32767; clipped = 1'b1; end
    if (v < -32768) begin v = -32768; clipped = 1'b1; end
    return v;
  endfunction

  task automatic model_edge();
    int v;
    bit c;
    for (int k = 0; k < 2; k++) begin
      m_fd[k] = 1'b0;
      m_rv[k] = rd_en;
      if (rd_en) m_rd[k] = (int'(rd_addr) < depth[k]) ? m_mem[k][rd_addr] : 16'h0000;
      if (enable) begin
        if (clear) begin
          m_state[k] = S_IDLE; m_ptr[k] = 0; m_ov[k] = 1'b0; m_sat[k] = 1'b0;
        end else if (in_valid) begin
          if (m_state[k] == S_FULL) m_ov[k] = 1'b1;
          else begin
            v = sat_of(int'(in_data), relu[k], c);
            m_mem[k][m_ptr[k]] = 16'(v);
            if (c) m_sat[k] = 1'b1;
            m_ptr[k] = m_ptr[k] + 1;
            m_state[k] = S_FILL;
            if (m_ptr[k] == depth[k]) begin
              m_state[k] = S_FULL; m_ptr[k] = 0; m_fd[k] = 1'b1;
            end
          end
        end
      end
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_state[k] = S_IDLE; m_ptr[k] = 0;
      m_ov[k] = 1'b0; m_sat[k] = 1'b0; m_fd[k] = 1'b0; m_rv[k] = 1'b0;
      m_rd[k] = 16'h0000;
    end
  endtask

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s[%0d] @%0t: got %0h, want %0h", tag, k, $time, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      chk("rd_data", k, 32'(rdd[k]), 32'(m_rd[k]));
      chk("rd_valid", k, 32'(rdv[k]), 32'(m_rv[k]));
      chk("frame_done", k, 32'(fdn[k]), 32'(m_fd[k]));
      chk("busy", k, 32'(bsy[k]), 32'(m_state[k] == S_FILL));
      chk("overflow", k, 32'(ovf[k]), 32'(m_ov[k]));
      chk("sat_flag", k, 32'(sat[k]), 32'(m_sat[k]));
    end
  endtask

  task automatic drive(input bit en, input bit clr, input bit iv, input int d,
                       input bit re, input int ra);
    enable = en; clear = clr; in_valid = iv; in_data = 17'(d);
    rd_en = re; rd_addr = 6'(ra);
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    enable = 1'b0; clear = 1'b0; in_valid = 1'b0; rd_en = 1'b0;
    rst_n = 1'b0;
    #2;
    model_reset();
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_all();
  endtask

  initial begin
    enable = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0;
    rd_en = 1'b0; rd_addr = '0;
    #1;
    do_reset();

    // Full frame of 0..63, then read everything back.
    for (int i = 0; i < 64; i++) drive(1, 0, 1, i, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 64; i++) drive(1, 0, 0, 0, 1, i);
    drive(1, 0, 0, 0, 0, 0);

    // Sample while FULL sets overflow and leaves the buffer alone.
    drive(1, 0, 1, 16'h7777, 0, 0);
    drive(1, 0, 0, 0, 1, 0);

    // Clear with coincident sample drops it; then ReLU/saturation corners.
    drive(1, 1, 1, 999, 0, 0);
    drive(1, 0, 1, -5, 0, 0);
    drive(1, 0, 1, 65535, 0, 0);
    drive(1, 0, 1, -40000, 0, 0);
    drive(1, 0, 1, 12345, 0, 0);
    for (int i = 0; i < 4; i++) drive(1, 0, 0, 0, 1, i);

    // Gated cycles mid-frame: nothing moves, reads still work.
    for (int i = 0; i < 10; i++)
      drive(0, 0, i[0], int'($urandom_range(0, 131071)), 1, int'($urandom_range(0, 63)));

    // Random traffic across several frames.
    for (int i = 0; i < 300; i++)
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 59) == 0,
            $urandom_range(0, 3) != 0, int'($urandom_range(0, 131071)) - 65536,
            $urandom_range(0, 1) == 1, int'($urandom_range(0, 63)));

    // Read-during-write at address 5 returns the old contents.
    drive(1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) drive(1, 0, 1, (i == 5) ? 16'h0042 : i, 0, 0);
    drive(1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) drive(1, 0, 1, 100 + i, 0, 0);
    drive(1, 0, 1, 16'h0123, 1, 5);
    drive(1, 0, 0, 0, 1, 5);

    // Reset after 20 samples abandons the frame; a new frame starts at 0.
    drive(1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) drive(1, 0, 1, 500 + i, 0, 0);
    do_reset();
    for (int i = 0; i < 64; i++) drive(1, 0, 1, 1000 + 3 * i, 0, 0);
    drive(1, 0, 0, 0, 1, 0);
    drive(1, 0, 0, 0, 1, 63);
    drive(1, 0, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
